// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants.
package riscv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold, or squash to a bubble.
module fetch_if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc4_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);
  if_id_t q_q, q_d;

  // A bubble keeps pc/pc4 so downstream debug still sees the last fetched address.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = '{pc: pc_i, pc4: pc4_i, instr: instr_i, valid: 1'b1};
    end else if (bubble_i) begin
      q_d.instr = NOP;
      q_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '{pc: '0, pc4: '0, instr: NOP, valid: 1'b0};
    else        q_q <= q_d;
  end

  assign pc_o    = q_q.pc;
  assign pc4_o   = q_q.pc4;
  assign instr_o = q_q.instr;
  assign valid_o = q_q.valid;
endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, next-PC select, halt detect, IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic            if_id_valid_o,
  output logic            misalign_o,
  output logic            halted_o
);
  localparam logic [XLEN-1:0] END_ADDR = XLEN'(IMEM_DEPTH * 4);
  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d, pc4;
  logic            misalign_q, misalign_d;
  logic            load, bubble;

  assign pc4         = pc_q + FOUR;
  assign imem_addr_o = pc_q;
  assign halted_o    = (pc_q >= END_ADDR);
  assign misalign_o  = misalign_q;

  // Priority: redirect > stall > halted > normal fetch.
  always_comb begin
    pc_d       = pc_q;
    load       = 1'b0;
    bubble     = 1'b0;
    misalign_d = 1'b0;
    if (redirect_i) begin
      pc_d       = {redirect_pc_i[XLEN-1:2], 2'b00};
      bubble     = 1'b1;
      misalign_d = |redirect_pc_i[1:0];
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (halted_o) begin
      bubble = 1'b1;
    end else begin
      load = 1'b1;
      pc_d = pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .bubble_i (bubble),
    .pc_i     (pc_q),
    .pc4_i    (pc4),
    .instr_i  (imem_rdata_i),
    .pc_o     (if_id_pc_o),
    .pc4_o    (if_id_pc4_o),
    .instr_o  (if_id_instr_o),
    .valid_o  (if_id_valid_o)
  );
endmodule
